mem_ctrl: RTL and testbench

Memory controller downstream of the load/store buffer and the instruction fetch unit. It arbitrates between their requests and serialises each access onto the byte-wide synchronous RAM/IO port. Loads are returned on the load CDB with sign or zero extension; stores complete with a done pulse. Wrong-path reads are aborted when a branch mispredicts; committed stores are never aborted.

---
 rtl/mem_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates load/store-buffer and instruction-fetch requests onto a
// byte-wide synchronous RAM/IO port, assembling loads and serialising stores.
`ifndef ROBBW
`define ROBBW 4
`endif

module mem_ctrl #(
    parameter logic [1:0] IO_ADDR_HI = 2'b11,
    parameter int         ROBBW      = `ROBBW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             jump_wrong,
    input  logic             io_buffer_full,
    input  logic [7:0]       mem_din,
    output logic [7:0]       mem_dout,
    output logic [31:0]      mem_a,
    output logic             mem_wr,
    input  logic             if_req_flag,
    input  logic [31:0]      if_req_addr,
    output logic             if_done_flag,
    output logic [31:0]      if_data,
    input  logic             lsb_req_flag,
    input  logic [1:0]       lsb_req_width,
    input  logic             lsb_req_type,
    input  logic             lsb_req_sign,
    input  logic [31:0]      lsb_req_addr,
    input  logic [31:0]      lsb_req_data,
    input  logic [ROBBW-1:0] lsb_req_rob_id,
    output logic             lsb_done_flag,
    output logic             ld_cdb_flag,
    output logic [ROBBW-1:0] ld_cdb_rob_id,
    output logic [31:0]      ld_cdb_val
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    function automatic logic [2:0] width_bytes(input logic [1:0] w);
        case (w)
            2'b00:   width_bytes = 3'd1;
            2'b01:   width_bytes = 3'd2;
            default: width_bytes = 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] v, input logic [1:0] w, input logic sg);
        case (w)
            2'b00:   extend = {{24{sg & v[7]}}, v[7:0]};
            2'b01:   extend = {{16{sg & v[15]}}, v[15:0]};
            default: extend = v;
        endcase
    endfunction

    state_t           state_r, state_s;
    logic [2:0]       cnt_r, cnt_s, nbytes_s;
    logic [31:0]      addr_r, addr_s, data_r, data_s, buf_r, buf_s, word_s;
    logic [1:0]       width_r, width_s, idx_s;
    logic             store_r, store_s, sign_r, sign_s, lsb_r, lsb_s, io_stall_s;
    logic [ROBBW-1:0] rob_r, rob_s, ld_rob_s;
    logic [31:0]      mem_a_s, if_data_s, ld_val_s;
    logic [7:0]       mem_dout_s;
    logic             mem_wr_s, if_done_s, lsb_done_s, ld_cdb_s;

    // Next-state, request latch, byte assembly and next-output logic
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        addr_s     = addr_r;
        data_s     = data_r;
        width_s    = width_r;
        store_s    = store_r;
        sign_s     = sign_r;
        rob_s      = rob_r;
        lsb_s      = lsb_r;
        buf_s      = buf_r;
        mem_a_s    = 32'h0000_0000;
        mem_wr_s   = 1'b0;
        mem_dout_s = 8'h00;
        if_done_s  = 1'b0;
        lsb_done_s = 1'b0;
        ld_cdb_s   = 1'b0;
        if_data_s  = if_data;
        ld_rob_s   = ld_cdb_rob_id;
        ld_val_s   = ld_cdb_val;
        nbytes_s   = width_bytes(width_r);
        io_stall_s = (addr_r[17:16] == IO_ADDR_HI) && io_buffer_full;
        // cnt_r counts BUSY cycles for reads; the byte on mem_din now is index cnt_r-1
        idx_s      = cnt_r[1:0] - 2'd1;
        word_s     = buf_r;
        word_s[{idx_s, 3'b000} +: 8] = mem_din;

        case (state_r)
            IDLE: begin
                if (lsb_req_flag && (lsb_req_type || !jump_wrong)) begin
                    state_s = BUSY;
                    addr_s  = lsb_req_addr;
                    data_s  = lsb_req_data;
                    width_s = lsb_req_width;
                    store_s = lsb_req_type;
                    sign_s  = lsb_req_sign;
                    rob_s   = lsb_req_rob_id;
                    lsb_s   = 1'b1;
                    buf_s   = 32'h0000_0000;
                    if (!lsb_req_type) begin
                        mem_a_s = lsb_req_addr;
                        cnt_s   = 3'd0;
                    end else if ((lsb_req_addr[17:16] == IO_ADDR_HI) && io_buffer_full) begin
                        cnt_s = 3'd0;
                    end else begin
                        mem_a_s    = lsb_req_addr;
                        mem_wr_s   = 1'b1;
                        mem_dout_s = lsb_req_data[7:0];
                        cnt_s      = 3'd1;
                    end
                end else if (if_req_flag && !jump_wrong) begin
                    state_s = BUSY;
                    addr_s  = if_req_addr;
                    width_s = 2'b11;
                    store_s = 1'b0;
                    sign_s  = 1'b0;
                    rob_s   = {ROBBW{1'b0}};
                    lsb_s   = 1'b0;
                    buf_s   = 32'h0000_0000;
                    mem_a_s = if_req_addr;
                    cnt_s   = 3'd0;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                if (store_r) begin
                    // for stores cnt_r is the number of bytes already issued
                    if (cnt_r == nbytes_s) begin
                        state_s    = DONE;
                        lsb_done_s = 1'b1;
                    end else if (io_stall_s) begin
                        cnt_s = cnt_r;
                    end else begin
                        mem_wr_s   = 1'b1;
                        mem_a_s    = addr_r + {29'd0, cnt_r};
                        mem_dout_s = data_r[{cnt_r[1:0], 3'b000} +: 8];
                        cnt_s      = cnt_r + 3'd1;
                    end
                end else if (jump_wrong) begin
                    state_s = IDLE;
                end else begin
                    if (cnt_r != 3'd0) begin
                        buf_s = word_s;
                    end else begin
                        buf_s = buf_r;
                    end
                    if (cnt_r == nbytes_s) begin
                        state_s = DONE;
                        if (lsb_r) begin
                            lsb_done_s = 1'b1;
                            ld_cdb_s   = 1'b1;
                            ld_rob_s   = rob_r;
                            ld_val_s   = extend(word_s, width_r, sign_r);
                        end else begin
                            if_done_s = 1'b1;
                            if_data_s = word_s;
                        end
                    end else begin
                        cnt_s = cnt_r + 3'd1;
                        if ((cnt_r + 3'd1) < nbytes_s) begin
                            mem_a_s = addr_r + {29'd0, cnt_r} + 32'd1;
                        end else begin
                            mem_a_s = 32'h0000_0000;
                        end
                    end
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, request latch and registered port outputs; rdy low freezes everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            cnt_r         <= 3'd0;
            addr_r        <= 32'h0000_0000;
            data_r        <= 32'h0000_0000;
            width_r       <= 2'b00;
            store_r       <= 1'b0;
            sign_r        <= 1'b0;
            rob_r         <= {ROBBW{1'b0}};
            lsb_r         <= 1'b0;
            buf_r         <= 32'h0000_0000;
            mem_a         <= 32'h0000_0000;
            mem_wr        <= 1'b0;
            mem_dout      <= 8'h00;
            if_done_flag  <= 1'b0;
            if_data       <= 32'h0000_0000;
            lsb_done_flag <= 1'b0;
            ld_cdb_flag   <= 1'b0;
            ld_cdb_rob_id <= {ROBBW{1'b0}};
            ld_cdb_val    <= 32'h0000_0000;
        end else if (rdy) begin
            state_r       <= state_s;
            cnt_r         <= cnt_s;
            addr_r        <= addr_s;
            data_r        <= data_s;
            width_r       <= width_s;
            store_r       <= store_s;
            sign_r        <= sign_s;
            rob_r         <= rob_s;
            lsb_r         <= lsb_s;
            buf_r         <= buf_s;
            mem_a         <= mem_a_s;
            mem_wr        <= mem_wr_s;
            mem_dout      <= mem_dout_s;
            if_done_flag  <= if_done_s;
            if_data       <= if_data_s;
            lsb_done_flag <= lsb_done_s;
            ld_cdb_flag   <= ld_cdb_s;
            ld_cdb_rob_id <= ld_rob_s;
            ld_cdb_val    <= ld_val_s;
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: byte RAM model, scoreboard of expected done
// pulses, a table of load/store vectors and sequences for arbitration, IO stall and flush.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst, rdy, jump_wrong, io_buffer_full;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        if_req_flag, if_done_flag;
    logic [31:0] if_req_addr, if_data;
    logic        lsb_req_flag, lsb_req_type, lsb_req_sign, lsb_done_flag, ld_cdb_flag;
    logic [1:0]  lsb_req_width;
    logic [31:0] lsb_req_addr, lsb_req_data, ld_cdb_val;
    logic [3:0]  lsb_req_rob_id, ld_cdb_rob_id;

    typedef struct { logic ld; logic [31:0] val; logic [3:0] rob; int cyc; } exp_t;
    typedef struct { logic [31:0] a; logic [7:0] d; int cyc; } wr_t;
    typedef struct { logic [1:0] w; logic st; logic sg; logic [31:0] a; logic [31:0] d;
                     logic [3:0] rob; logic [31:0] ev; int lat; } vec_t;

    exp_t lsb_q[$];
    exp_t if_q[$];
    exp_t mon_e;
    wr_t  wlog[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    logic [7:0]  ram [0:262143];
    logic        pre_en = 1'b0;
    logic [17:0] pre_addr = 18'd0;
    logic [7:0]  pre_data = 8'h00;

    mem_ctrl #(.IO_ADDR_HI(2'b11), .ROBBW(4)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .jump_wrong(jump_wrong),
        .io_buffer_full(io_buffer_full), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_a(mem_a), .mem_wr(mem_wr), .if_req_flag(if_req_flag),
        .if_req_addr(if_req_addr), .if_done_flag(if_done_flag), .if_data(if_data),
        .lsb_req_flag(lsb_req_flag), .lsb_req_width(lsb_req_width),
        .lsb_req_type(lsb_req_type), .lsb_req_sign(lsb_req_sign),
        .lsb_req_addr(lsb_req_addr), .lsb_req_data(lsb_req_data),
        .lsb_req_rob_id(lsb_req_rob_id), .lsb_done_flag(lsb_done_flag),
        .ld_cdb_flag(ld_cdb_flag), .ld_cdb_rob_id(ld_cdb_rob_id), .ld_cdb_val(ld_cdb_val)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous byte RAM: read data appears the cycle after the address
    always @(posedge clk) begin
        if (pre_en) ram[pre_addr] <= pre_data;
        else if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
        mem_din <= ram[mem_a[17:0]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: every done pulse is matched to the oldest pending expectation
    always @(negedge clk) begin
        if (mem_wr) wlog.push_back('{mem_a, mem_dout, cyc});
        if (lsb_done_flag) begin
            if (lsb_q.size() == 0) begin
                chk("lsb unexpected done", {31'b0, lsb_done_flag}, 32'd0);
            end else begin
                mon_e = lsb_q.pop_front();
                chk("lsb done cycle", cyc, mon_e.cyc);
                chk("ld_cdb_flag", {31'b0, ld_cdb_flag}, {31'b0, mon_e.ld});
                if (mon_e.ld) begin
                    chk("ld_cdb_val", ld_cdb_val, mon_e.val);
                    chk("ld_cdb_rob_id", {28'b0, ld_cdb_rob_id}, {28'b0, mon_e.rob});
                end
            end
        end else if (ld_cdb_flag) begin
            chk("cdb without done", {31'b0, ld_cdb_flag}, 32'd0);
        end
        if (if_done_flag) begin
            if (if_q.size() == 0) begin
                chk("fetch unexpected done", {31'b0, if_done_flag}, 32'd0);
            end else begin
                mon_e = if_q.pop_front();
                chk("fetch done cycle", cyc, mon_e.cyc);
                chk("if_data", if_data, mon_e.val);
            end
        end
    end

    task automatic poke(input logic [17:0] a, input logic [7:0] d);
        pre_addr = a;
        pre_data = d;
        pre_en   = 1'b1;
        @(posedge clk);
        #1;
        pre_en = 1'b0;
    endtask

    task automatic set_lsb(input logic [1:0] w, input logic st, input logic sg,
                           input logic [31:0] a, input logic [31:0] d, input logic [3:0] rob);
        lsb_req_width  = w;
        lsb_req_type   = st;
        lsb_req_sign   = sg;
        lsb_req_addr   = a;
        lsb_req_data   = d;
        lsb_req_rob_id = rob;
        lsb_req_flag   = 1'b1;
    endtask

    task automatic lsb_access(input logic [1:0] w, input logic st, input logic sg,
                              input logic [31:0] a, input logic [31:0] d, input logic [3:0] rob,
                              input logic [31:0] ev, input int lat, output int c0);
        int n;
        logic got;
        @(posedge clk);
        #1;
        set_lsb(w, st, sg, a, d, rob);
        c0 = cyc;
        lsb_q.push_back('{!st, ev, rob, cyc + lat});
        n = 0;
        got = 1'b0;
        while (!got && n < 60) begin
            @(negedge clk);
            n++;
            got = lsb_done_flag;
        end
        chk("lsb done seen", {31'b0, got}, 32'd1);
        @(posedge clk);
        #1;
        lsb_req_flag = 1'b0;
    endtask

    task automatic fetch_access(input logic [31:0] a, input logic [31:0] ev, input int lat,
                                output int c0);
        int n;
        logic got;
        @(posedge clk);
        #1;
        if_req_addr = a;
        if_req_flag = 1'b1;
        c0 = cyc;
        if_q.push_back('{1'b0, ev, 4'd0, cyc + lat});
        n = 0;
        got = 1'b0;
        while (!got && n < 60) begin
            @(negedge clk);
            n++;
            got = if_done_flag;
        end
        chk("fetch done seen", {31'b0, got}, 32'd1);
        @(posedge clk);
        #1;
        if_req_flag = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int c1;
        vec_t v [14];
        logic [31:0] sw_d;
        v[0]  = '{2'b11, 1'b0, 1'b1, 32'h0000_0100, 32'h0, 4'd1,  32'h1234_5678, 6};
        v[1]  = '{2'b00, 1'b0, 1'b1, 32'h0000_0110, 32'h0, 4'd2,  32'hFFFF_FF80, 3};
        v[2]  = '{2'b00, 1'b0, 1'b0, 32'h0000_0110, 32'h0, 4'd3,  32'h0000_0080, 3};
        v[3]  = '{2'b01, 1'b0, 1'b1, 32'h0000_0120, 32'h0, 4'd4,  32'hFFFF_8000, 4};
        v[4]  = '{2'b01, 1'b0, 1'b0, 32'h0000_0120, 32'h0, 4'd5,  32'h0000_8000, 4};
        v[5]  = '{2'b01, 1'b0, 1'b1, 32'h0000_0103, 32'h0, 4'd6,  32'hFFFF_9A12, 4};
        v[6]  = '{2'b00, 1'b0, 1'b1, 32'h0000_0130, 32'h0, 4'd7,  32'h0000_007F, 3};
        v[7]  = '{2'b11, 1'b1, 1'b0, 32'h0000_0200, 32'hDEAD_BEEF, 4'd8, 32'h0, 5};
        v[8]  = '{2'b11, 1'b0, 1'b0, 32'h0000_0200, 32'h0, 4'd9,  32'hDEAD_BEEF, 6};
        v[9]  = '{2'b00, 1'b1, 1'b0, 32'h0000_0201, 32'h0000_00A5, 4'd10, 32'h0, 2};
        v[10] = '{2'b11, 1'b0, 1'b0, 32'h0000_0200, 32'h0, 4'd11, 32'hDEAD_A5EF, 6};
        v[11] = '{2'b01, 1'b1, 1'b0, 32'h0000_0300, 32'h1234_ABCD, 4'd12, 32'h0, 3};
        v[12] = '{2'b11, 1'b0, 1'b0, 32'h0000_0300, 32'h0, 4'd13, 32'hFFFF_ABCD, 6};
        v[13] = '{2'b11, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0, 4'd14, 32'h4433_2211, 6};

        rst = 1'b1; rdy = 1'b1; jump_wrong = 1'b0; io_buffer_full = 1'b0;
        if_req_flag = 1'b0; if_req_addr = 32'h0;
        set_lsb(2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
        lsb_req_flag = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst mem_a", mem_a, 32'd0);
        chk("rst mem_wr", {31'b0, mem_wr}, 32'd0);
        chk("rst mem_dout", {24'b0, mem_dout}, 32'd0);
        chk("rst flags", {29'b0, if_done_flag, lsb_done_flag, ld_cdb_flag}, 32'd0);
        chk("rst if_data", if_data, 32'd0);
        chk("rst ld_cdb_val", ld_cdb_val, 32'd0);
        chk("rst ld_cdb_rob_id", {28'b0, ld_cdb_rob_id}, 32'd0);

        poke(18'h100, 8'h78); poke(18'h101, 8'h56); poke(18'h102, 8'h34); poke(18'h103, 8'h12);
        poke(18'h104, 8'h9A); poke(18'h110, 8'h80); poke(18'h120, 8'h00); poke(18'h121, 8'h80);
        poke(18'h130, 8'h7F); poke(18'h300, 8'hFF); poke(18'h301, 8'hFF); poke(18'h302, 8'hFF);
        poke(18'h303, 8'hFF); poke(18'h3FFFF, 8'h11); poke(18'h0, 8'h22); poke(18'h1, 8'h33);
        poke(18'h2, 8'h44);
        rst = 1'b0;

        for (int i = 0; i < 14; i++)
            lsb_access(v[i].w, v[i].st, v[i].sg, v[i].a, v[i].d, v[i].rob, v[i].ev, v[i].lat, c0);

        // LW address trace: mem_a = 0x100..0x103 in cycles 1-4, reads only
        fork
            lsb_access(2'b11, 1'b0, 1'b0, 32'h100, 32'h0, 4'd13, 32'h1234_5678, 6, c0);
            begin
                @(posedge clk); #1;
                for (int k = 0; k < 4; k++) begin
                    @(posedge clk); #1;
                    chk("lw trace mem_a", mem_a, 32'h100 + k);
                    chk("lw trace mem_wr", {31'b0, mem_wr}, 32'd0);
                end
            end
        join

        // SW byte trace: little-endian bytes at consecutive addresses, cycles 1-4
        wlog.delete();
        sw_d = 32'hCAFE_F00D;
        lsb_access(2'b11, 1'b1, 1'b0, 32'h600, sw_d, 4'd2, 32'h0, 5, c0);
        chk("sw write count", wlog.size(), 32'd4);
        for (int k = 0; k < 4 && k < wlog.size(); k++) begin
            chk("sw write addr", wlog[k].a, 32'h600 + k);
            chk("sw write data", {24'b0, wlog[k].d}, {24'b0, sw_d[8*k +: 8]});
            chk("sw write cycle", wlog[k].cyc, c0 + 1 + k);
        end

        // Simultaneous requests: LSB first, fetch accepted after DONE + 1 IDLE
        fork
            lsb_access(2'b00, 1'b0, 1'b1, 32'h110, 32'h0, 4'd3, 32'hFFFF_FF80, 3, c0);
            fetch_access(32'h100, 32'h1234_5678, 10, c1);
        join

        // IO store stalled three cycles by io_buffer_full
        wlog.delete();
        fork
            lsb_access(2'b00, 1'b1, 1'b0, 32'h0003_0000, 32'h0000_005A, 4'd4, 32'h0, 5, c0);
            begin
                @(posedge clk); #1;
                io_buffer_full = 1'b1;
                repeat (3) @(posedge clk);
                #1;
                io_buffer_full = 1'b0;
            end
        join
        chk("io write count", wlog.size(), 32'd1);
        if (wlog.size() > 0) begin
            chk("io write addr", wlog[0].a, 32'h0003_0000);
            chk("io write data", {24'b0, wlog[0].d}, 32'h5A);
            chk("io write cycle", wlog[0].cyc, c0 + 4);
        end

        // Mispredict in cycle 2 of a load: aborted, no done or cdb pulse
        @(posedge clk); #1;
        set_lsb(2'b11, 1'b0, 1'b0, 32'h100, 32'h0, 4'd5);
        @(posedge clk); #1;
        chk("lw flush mem_a c1", mem_a, 32'h100);
        @(posedge clk); #1;
        chk("lw flush mem_a c2", mem_a, 32'h101);
        jump_wrong = 1'b1;
        lsb_req_flag = 1'b0;
        @(posedge clk); #1;
        jump_wrong = 1'b0;
        chk("lw flush mem_a c3", mem_a, 32'd0);
        chk("lw flush mem_wr c3", {31'b0, mem_wr}, 32'd0);
        repeat (8) @(posedge clk);

        // Mispredict in cycle 2 of a store: store still completes
        wlog.delete();
        fork
            lsb_access(2'b11, 1'b1, 1'b0, 32'h400, 32'h1122_3344, 4'd6, 32'h0, 5, c0);
            begin
                repeat (3) begin @(posedge clk); #1; end
                jump_wrong = 1'b1;
                @(posedge clk); #1;
                jump_wrong = 1'b0;
            end
        join
        chk("sw flush write count", wlog.size(), 32'd4);
        lsb_access(2'b11, 1'b0, 1'b0, 32'h400, 32'h0, 4'd7, 32'h1122_3344, 6, c0);

        // Mispredict in IDLE: fetch held off, store still accepted
        fork
            fetch_access(32'h100, 32'h1234_5678, 8, c1);
            begin
                @(posedge clk); #1;
                jump_wrong = 1'b1;
                @(posedge clk); #1;
                @(posedge clk); #1;
                jump_wrong = 1'b0;
            end
        join
        fork
            lsb_access(2'b00, 1'b1, 1'b0, 32'h700, 32'h0000_003C, 4'd8, 32'h0, 2, c0);
            begin
                @(posedge clk); #1;
                jump_wrong = 1'b1;
                @(posedge clk); #1;
                jump_wrong = 1'b0;
            end
        join
        lsb_access(2'b00, 1'b0, 1'b0, 32'h700, 32'h0, 4'd9, 32'h0000_003C, 3, c0);

        // Reset in the middle of a store: partial store, no done pulse
        wlog.delete();
        @(posedge clk); #1;
        set_lsb(2'b11, 1'b1, 1'b0, 32'h500, 32'h5566_7788, 4'd10);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        lsb_req_flag = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst mid mem_wr", {31'b0, mem_wr}, 32'd0);
        chk("rst mid mem_a", mem_a, 32'd0);
        repeat (6) @(posedge clk);
        #1;
        chk("rst mid write count", wlog.size(), 32'd2);

        chk("lsb scoreboard drained", lsb_q.size(), 32'd0);
        chk("fetch scoreboard drained", if_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
